text_glyph_renderer: RTL and testbench

Character-cell text renderer that sits between the video timing generator and the HDMI/LCD pixel output. For each active pixel it reads a character code from the text buffer RAM, then the matching glyph row from the 8x16 ASCII font ROM (address = {code[6:0], glyph_row[3:0]}, 1-cycle registered read). It selects the pixel bit and emits an RGB pixel with delay-matched sync/enable. It also handles bit-7 inverse video and a blinking underline cursor.

---
 rtl/text_glyph_renderer.sv | 164 ++++++++++++++++
 tb/tb_text_glyph_renderer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/text_glyph_renderer.sv
// ============================================================================
// text_glyph_renderer : 3-stage character-cell text renderer (8x16 font)
// Revision 1.0
// ============================================================================
`default_nettype none

module text_glyph_renderer #(
  parameter int          COLS         = 80,
  parameter int          ROWS         = 30,
  parameter logic [23:0] FG_RGB       = 24'hFFFFFF,
  parameter logic [23:0] BG_RGB       = 24'h000000,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] pix_x,
  input  logic [11:0] pix_y,
  input  logic        de_in,
  input  logic        hs_in,
  input  logic        vs_in,
  output logic [11:0] txt_addr,
  input  logic [7:0]  txt_data,
  output logic [10:0] font_ad,
  input  logic [7:0]  font_dout,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  output logic [23:0] rgb_out,
  output logic        de_out,
  output logic        hs_out,
  output logic        vs_out
);

  localparam int             FCW           = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FCW-1:0] C_FRAME_LAST  = FCW'(BLINK_FRAMES - 1);
  localparam logic [8:0]     C_COLS        = 9'(COLS);
  localparam logic [7:0]     C_ROWS        = 8'(ROWS);
  localparam logic [11:0]    C_COLS12      = 12'(COLS);

  typedef struct packed {
    logic [3:0] glyph_row;
    logic [2:0] glyph_bit;
    logic       in_area;
    logic       de;
    logic       hs;
    logic       vs;
    logic       cursor_hit;
  } stage1_t;

  typedef struct packed {
    logic [2:0] glyph_bit;
    logic       in_area;
    logic       de;
    logic       hs;
    logic       vs;
    logic       cursor_hit;
    logic       inv;
  } stage2_t;

  stage1_t        s1_d, s1_q;
  stage2_t        s2_d, s2_q;
  logic [23:0]    rgb_d, rgb_q;
  logic           de_d, de_q, hs_d, hs_q, vs_d, vs_q;
  logic           vs_prev_d, vs_prev_q;
  logic [FCW-1:0] frame_cnt_d, frame_cnt_q;
  logic           blink_d, blink_q;

  logic [8:0]     w_cell_col;
  logic [7:0]     w_cell_row;
  logic           w_in_area;
  logic           w_lit;

  always_comb begin
    w_cell_col = pix_x[11:3];
    w_cell_row = pix_y[11:4];
    w_in_area  = de_in && (w_cell_col < C_COLS) && (w_cell_row < C_ROWS);

    // 12-bit product is exact for every in-area cell while COLS*ROWS <= 4096
    txt_addr = w_in_area ? (12'(w_cell_row) * C_COLS12 + 12'(w_cell_col)) : 12'd0;

    // txt_data now belongs to the pixel held in stage 1
    font_ad = {txt_data[6:0], s1_q.glyph_row};

    s1_d.glyph_row  = pix_y[3:0];
    s1_d.glyph_bit  = pix_x[2:0];
    s1_d.in_area    = w_in_area;
    s1_d.de         = de_in;
    s1_d.hs         = hs_in;
    s1_d.vs         = vs_in;
    s1_d.cursor_hit = cursor_en && blink_q
                      && ({2'b00, cursor_col} == w_cell_col)
                      && ({3'b000, cursor_row} == w_cell_row)
                      && (pix_y[3:0] >= 4'd14);

    s2_d.glyph_bit  = s1_q.glyph_bit;
    s2_d.in_area    = s1_q.in_area;
    s2_d.de         = s1_q.de;
    s2_d.hs         = s1_q.hs;
    s2_d.vs         = s1_q.vs;
    s2_d.cursor_hit = s1_q.cursor_hit;
    s2_d.inv        = txt_data[7];

    // ~bit == 7-bit: font bit 7 is the leftmost pixel of the cell
    w_lit = font_dout[~s2_q.glyph_bit] ^ s2_q.inv;
    if (s2_q.cursor_hit) begin
      w_lit = 1'b1;
    end

    if (!s2_q.de) begin
      rgb_d = 24'h000000;
    end else if (!s2_q.in_area) begin
      rgb_d = BG_RGB;
    end else begin
      rgb_d = w_lit ? FG_RGB : BG_RGB;
    end
    de_d = s2_q.de;
    hs_d = s2_q.hs;
    vs_d = s2_q.vs;

    vs_prev_d   = vs_in;
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    if (vs_in && !vs_prev_q) begin
      if (frame_cnt_q == C_FRAME_LAST) begin
        frame_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q        <= '0;
      s2_q        <= '0;
      rgb_q       <= '0;
      de_q        <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      vs_prev_q   <= 1'b0;
      frame_cnt_q <= '0;
      blink_q     <= 1'b1;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      rgb_q       <= rgb_d;
      de_q        <= de_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      vs_prev_q   <= vs_prev_d;
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign rgb_out = rgb_q;
  assign de_out  = de_q;
  assign hs_out  = hs_q;
  assign vs_out  = vs_q;

endmodule

`default_nettype wire

// File: tb/tb_text_glyph_renderer.sv
// ============================================================================
// tb_text_glyph_renderer : scoreboard bench with behavioural text/cursor model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_text_glyph_renderer;

  localparam int          COLS   = 80;
  localparam int          ROWS   = 30;
  localparam logic [23:0] FG     = 24'hFFFFFF;
  localparam logic [23:0] BG     = 24'h000000;
  localparam int          BLINKF = 30;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] pix_x = '0, pix_y = '0;
  logic        de_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0;
  logic [11:0] txt_addr;
  logic [7:0]  txt_data;
  logic [10:0] font_ad;
  logic [7:0]  font_dout;
  logic        cursor_en = 1'b0;
  logic [6:0]  cursor_col = '0;
  logic [4:0]  cursor_row = '0;
  logic [23:0] rgb_out;
  logic        de_out, hs_out, vs_out;

  text_glyph_renderer #(
    .COLS(COLS), .ROWS(ROWS), .FG_RGB(FG), .BG_RGB(BG), .BLINK_FRAMES(BLINKF)
  ) dut (
    .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y),
    .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
    .txt_addr(txt_addr), .txt_data(txt_data),
    .font_ad(font_ad), .font_dout(font_dout),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .rgb_out(rgb_out), .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External memories with exactly one cycle of read latency
  logic [7:0] txt_mem [4096];
  logic [7:0] font_mem[2048];
  always @(posedge clk) begin
    txt_data  <= txt_mem[txt_addr];
    font_dout <= font_mem[font_ad];
  end

  typedef struct {
    int          due;
    logic [23:0] rgb;
    logic        de, hs, vs;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: blink counter driven by vs rising edges
  int   m_frame = 0;
  bit   m_blink = 1'b1;
  bit   m_vs_prev = 1'b0;
  bit   pv_valid = 1'b0;
  logic [10:0] pv_font = '0;

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic drive(input bit rst, input int x, input int y, input bit de, input bit hs,
                       input bit vs, input bit ce, input int cc, input int cr);
    exp_t e;
    int col, row, addr, gr, ci, b;
    bit in_area, hit, lit;
    logic [7:0] code, glyph;
    @(negedge clk);
    if (pv_valid) begin
      checks++;
      if (font_ad !== pv_font) begin
        errors++;
        $display("FAIL font_ad cyc=%0d got=%h want=%h", cyc, font_ad, pv_font);
      end
    end
    reset = rst; pix_x = 12'(x); pix_y = 12'(y);
    de_in = de; hs_in = hs; vs_in = vs;
    cursor_en = ce; cursor_col = 7'(cc); cursor_row = 5'(cr);

    col = x / 8; row = y / 16; gr = y % 16;
    in_area = de && (col < COLS) && (row < ROWS);
    addr = in_area ? row * COLS + col : 0;
    code = txt_mem[addr];
    ci = int'(code[6:0]);
    glyph = font_mem[ci * 16 + gr];
    b = 7 - (x % 8);
    hit = ce && m_blink && (col == cc) && (row == cr) && (gr >= 14);
    lit = hit ? 1'b1 : (glyph[b] ^ code[7]);

    e.due = cyc + 3;
    if (rst) begin
      e.rgb = '0; e.de = 1'b0; e.hs = 1'b0; e.vs = 1'b0;
      // anything still in flight is flushed, including what the output register shows next
      foreach (sb[i]) if (sb[i].due >= cyc + 1) begin
        sb[i].rgb = '0; sb[i].de = 1'b0; sb[i].hs = 1'b0; sb[i].vs = 1'b0;
      end
      m_frame = 0; m_blink = 1'b1; m_vs_prev = 1'b0;
      pv_valid = 1'b0;
    end else begin
      e.rgb = !de ? 24'h0 : (!in_area ? BG : (lit ? FG : BG));
      e.de = de; e.hs = hs; e.vs = vs;
      if (vs && !m_vs_prev) begin
        if (m_frame == BLINKF - 1) begin
          m_frame = 0; m_blink = !m_blink;
        end else begin
          m_frame++;
        end
      end
      m_vs_prev = vs;
      pv_valid = 1'b1;
      pv_font = 11'(ci * 16 + gr);
    end
    sb.push_back(e);
    #1;
    check_val("txt_addr", int'(txt_addr), addr);
  endtask

  task automatic set_txt(input int a, input logic [7:0] v);
    @(posedge clk); #1;
    txt_mem[a] = v;
  endtask

  // Monitor: compares every expected pixel on the cycle it is due
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.due != cyc || rgb_out !== e.rgb || de_out !== e.de ||
            hs_out !== e.hs || vs_out !== e.vs) begin
          errors++;
          $display("FAIL pixel due=%0d cyc=%0d got rgb=%h de=%b hs=%b vs=%b want rgb=%h de=%b hs=%b vs=%b",
                   e.due, cyc, rgb_out, de_out, hs_out, vs_out, e.rgb, e.de, e.hs, e.vs);
        end
      end
    end
  end

  initial begin
    int x, y, cc, cr;
    for (int i = 0; i < 4096; i++) txt_mem[i] = 8'($urandom);
    for (int i = 0; i < 2048; i++) font_mem[i] = 8'($urandom);
    txt_mem[0] = 8'h41;
    font_mem[16'h41 * 16 + 3] = 8'h38;
    txt_mem[2 * COLS + 5] = 8'h20;
    for (int r = 0; r < 16; r++) font_mem[16'h20 * 16 + r] = 8'h00;

    // reset with de_in high
    drive(1, 0, 0, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0, 0, 0, 0);

    // 'A' row 3 and its inverse-video form
    for (int i = 0; i < 8; i++) drive(0, i, 3, 1, 0, 0, 0, 0, 0);
    set_txt(0, 8'hC1);
    for (int i = 0; i < 8; i++) drive(0, i, 3, 1, 0, 0, 0, 0, 0);

    // outside the text area and blanking
    drive(0, 640, 10, 1, 0, 0, 0, 0, 0);
    drive(0, 640, 10, 0, 0, 0, 0, 0, 0);
    drive(0, 639, 479, 1, 0, 0, 0, 0, 0);
    check_val("txt_addr_last_cell", int'(txt_addr), 2399);
    drive(0, 799, 479, 1, 0, 0, 0, 0, 0);
    check_val("txt_addr_clamped", int'(txt_addr), 0);

    // cursor blink across 30 and 60 vs rising edges
    for (int ph = 0; ph < 3; ph++) begin
      drive(0, 40, 47, 1, 0, 0, 1, 5, 2);
      drive(0, 40, 45, 1, 0, 0, 1, 5, 2);
      drive(0, 40, 47, 1, 0, 0, 0, 5, 2);
      if (ph < 2) begin
        for (int k = 0; k < BLINKF; k++) begin
          drive(0, 0, 0, 0, 0, 1, 1, 5, 2);
          drive(0, 0, 0, 0, 0, 0, 1, 5, 2);
        end
      end
    end

    // a short line with a 96-cycle hsync pulse then a vsync pulse
    for (int i = 0; i < 140; i++)
      drive(0, i, 20, (i < 16), (i >= 20 && i < 116), (i == 130), 0, 0, 0);

    // mid-line reset flushes the pipeline
    for (int i = 0; i < 4; i++) drive(0, 8 + i, 5, 1, 0, 0, 0, 0, 0);
    drive(1, 12, 5, 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 13 + i, 5, 1, 0, 0, 0, 0, 0);

    // randomized pixels, syncs and cursor positions
    for (int n = 0; n < 1500; n++) begin
      x = int'($urandom_range(0, 799));
      y = int'($urandom_range(0, 524));
      if ($urandom_range(0, 1) == 1) begin
        cc = (x / 8) % 128; cr = (y / 16) % 32;
      end else begin
        cc = int'($urandom_range(0, 127)); cr = int'($urandom_range(0, 31));
      end
      drive(0, x, y, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), cc, cr);
    end

    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #2;
    check_val("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
